sik_decode_stage: RTL and testbench
===================================

Name: sik_decode_stage

Overview:
- Second pipeline stage of the two-thread SIK stack processor: consumes fetched instruction words tagged with thread ID, produces fully decoded micro-ops for the register-read/ALU stage.
- Per thread, owns the prefix state (pre value + loaded flag), the speculative stack pointer and the halt flag.
- Emits regfile indices as {thread, sp8} into the 512-word regfile.

Parameters:
- WORD_W, 16, instruction/data width.
- SP_W, 8, per-thread stack pointer width; the regfile index is 1+SP_W bits.
- SP_INIT, 8'hFF, stack pointer value after reset (empty stack).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  fetched word present.
- in_ready  out  1  stage accepts the word this cycle.
- in_tid  in  1  thread of the fetched word.
- in_pc  in  16  PC of the fetched word.
- in_inst  in  16  instruction word.
- out_valid  out  1  decoded micro-op present.
- out_ready  in  1  downstream accepts the micro-op.
- out_tid  out  1  thread of the micro-op.
- out_pc  out  16  PC of the micro-op.
- out_op  out  4  ALU opcode (OPadd, OPsub, OPand, OPor, OPxor, OPlt; else pass-through).
- out_cls  out  4  class: ALU, PUSH, GET, PUT, POP, CALL, RET, JUMP, JUMPF, JUMPT, LOAD, STORE, DUP, TEST, SYS.
- out_imm  out  16  resolved immediate.
- out_src  out  9  source regfile index.
- out_dst  out  9  destination regfile index.
- flush  in  1  branch redirect from downstream.
- flush_tid  in  1  thread to flush.
- flush_sp  in  8  architectural SP to restore for flush_tid.
- halted  out  2  per-thread halt flags.

Behaviour:
- Reset (reset low, async):
  - out_valid=0; in_ready=1; halted=0.
  - Both SPs = SP_INIT; both pre=0, loaded=0.
  - All other outputs 0.
- Handshake:
  - A one-entry output register.
  - in_ready = !out_valid || out_ready.
  - A word is accepted when in_valid && in_ready && !halted[in_tid].
  - A word for a halted thread is consumed (in_ready asserted) and dropped. No micro-op is emitted and no state changes.
  - Latency is 1 cycle from acceptance to out_valid.
  - The output holds stable while out_valid && !out_ready.
- Instruction fields:
  - opcode = inst[15:12]; opcode 0000 means an extended op in inst[3:0].
  - immed12 = inst[11:0].
- Immediate resolution:
  - If loaded[tid], imm = {pre, immed12} and loaded clears on acceptance.
  - Otherwise imm = sign-extended immed12.
  - PRE (1111) sets pre = inst[3:0] and loaded=1, and emits no micro-op.
  - A PRE for a thread that is already loaded overwrites pre.
- SP effects (sp = current thread SP, 8-bit mod-256 arithmetic):
  - PUSH, CALL, DUP: dst=sp+1; sp+=1.
  - GET: src=sp-imm[7:0]; dst=sp+1; sp+=1.
  - PUT: src=sp; dst=sp-imm[7:0]; sp unchanged.
  - POP, RET, JUMPF, JUMPT: src=sp; sp-=1.
  - ALU ops, LT, STORE: src=sp; dst=sp-1; sp-=1.
  - LOAD, TEST: src=dst=sp; sp unchanged.
  - JUMP: no SP change.
  - SYS or any undefined encoding: class SYS; sets halted[tid] on acceptance.
- Thread independence: thread 0 and thread 1 state never interact.
- flush (highest priority):
  - SP[flush_tid] = flush_sp; loaded[flush_tid] = 0.
  - If out_valid && out_tid==flush_tid, out_valid clears the same cycle.
  - An input word for flush_tid in the same cycle is dropped with in_ready=1.
  - A flush of the other thread does not disturb the accepted word.
- Wrap-around: SP 0xFF+1 -> 0x00 and 0x00-1 -> 0xFF, silently (see option).
- Once both halted bits are set, the stage accepts nothing new beyond dropping.

Optional Feature:
- Macro SIK_STACK_CHECK_EN.
- When defined:
  - Adds output port trap (1 bit).
  - An accepted op that would move SP past 0xFE->0xFF (overflow) or pop at SP==0xFF (underflow) is converted to class SYS. trap pulses for one cycle with out_valid, and halted[tid] sets.
- When undefined: there is no trap port and SP wraps silently.

Decomposition:
- Shared package sik_pkg holds:
  - Opcode and extended-op encodings (OPget..OPpre, OPadd..OPtest).
  - Class encodings.
  - WORD, HALFWORD and PRE widths.
  - SP_INIT.
- One natural sub-module, sik_op_classify: purely combinational inst -> {cls, alu op, sp delta, src/dst offset select}.
- sik_decode_stage holds all sequential state.

Test Plan:
1. Reset, then tid0 PUSH 0x005 -> out_cls=PUSH, imm=0x0005, dst=9'h000, SP0=0x00; tid1 PUSH 0xFFF -> imm=0xFFFF, dst=9'h100.
2. tid0 PRE 0xA then PUSH 0x123 -> a single micro-op with imm=0xA123; the next PUSH 0x001 gives imm=0x0001 (loaded cleared).
3. SP0=0x03, tid0 ADD -> src=0x003, dst=0x002, SP0=0x02; GET 2 -> src=0x000, dst=0x003.
4. out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0 and outputs stable; release -> the next word follows one cycle later and none is lost.
5. flush tid1 flush_sp=0x10 while a tid1 op sits in the output reg -> out_valid=0, SP1=0x10; the next tid1 PUSH gives dst=9'h111.
6. tid0 SYS -> halted=2'b01; further tid0 words are dropped with no output; tid1 continues. With SIK_STACK_CHECK_EN, POP at SP0=0xFF -> trap=1, halted[0]=1.

Source files
------------

// File: rtl/sik_pkg.sv
// Shared encodings for the SIK decode stage: opcodes, extended ops,
// micro-op classes, field widths and the reset stack pointer.
package sik_pkg;

  localparam int WORD     = 16;
  localparam int HALFWORD = 8;
  localparam int PRE      = 4;

  // Empty-stack pointer value after reset.
  localparam logic [7:0] SP_INIT = 8'hFF;

  // Primary opcodes in inst[15:12]; 0xA..0xE are undefined.
  localparam logic [3:0] OPopr   = 4'h0;
  localparam logic [3:0] OPget   = 4'h1;
  localparam logic [3:0] OPput   = 4'h2;
  localparam logic [3:0] OPpush  = 4'h3;
  localparam logic [3:0] OPload  = 4'h4;
  localparam logic [3:0] OPstore = 4'h5;
  localparam logic [3:0] OPcall  = 4'h6;
  localparam logic [3:0] OPjump  = 4'h7;
  localparam logic [3:0] OPjumpf = 4'h8;
  localparam logic [3:0] OPjumpt = 4'h9;
  localparam logic [3:0] OPpre   = 4'hF;

  // Extended ops in inst[3:0] when opcode is OPopr; 0xA..0xF decode as SYS.
  localparam logic [3:0] OPadd  = 4'h0;
  localparam logic [3:0] OPsub  = 4'h1;
  localparam logic [3:0] OPand  = 4'h2;
  localparam logic [3:0] OPor   = 4'h3;
  localparam logic [3:0] OPxor  = 4'h4;
  localparam logic [3:0] OPlt   = 4'h5;
  localparam logic [3:0] OPpop  = 4'h6;
  localparam logic [3:0] OPret  = 4'h7;
  localparam logic [3:0] OPdup  = 4'h8;
  localparam logic [3:0] OPtest = 4'h9;

  // ALU op for non-ALU classes: operand passes straight through.
  localparam logic [3:0] ALU_PASS = 4'hF;

  typedef enum logic [3:0] {
    CLS_ALU   = 4'h0,
    CLS_PUSH  = 4'h1,
    CLS_GET   = 4'h2,
    CLS_PUT   = 4'h3,
    CLS_POP   = 4'h4,
    CLS_CALL  = 4'h5,
    CLS_RET   = 4'h6,
    CLS_JUMP  = 4'h7,
    CLS_JUMPF = 4'h8,
    CLS_JUMPT = 4'h9,
    CLS_LOAD  = 4'hA,
    CLS_STORE = 4'hB,
    CLS_DUP   = 4'hC,
    CLS_TEST  = 4'hD,
    CLS_SYS   = 4'hE
  } cls_e;

  typedef enum logic [1:0] {SPD_NONE, SPD_INC, SPD_DEC} sp_delta_e;
  typedef enum logic [1:0] {SRC_NONE, SRC_SP, SRC_SP_MINUS_IMM} src_sel_e;
  typedef enum logic [2:0] {DST_NONE, DST_SP, DST_SP_PLUS1, DST_SP_MINUS1, DST_SP_MINUS_IMM} dst_sel_e;

  typedef struct packed {
    cls_e      cls;
    logic [3:0] alu_op;
    sp_delta_e delta;
    src_sel_e  src_sel;
    dst_sel_e  dst_sel;
    logic      is_pre;
  } uop_ctl_t;

endpackage

// File: rtl/sik_op_classify.sv
// Purely combinational instruction classifier: opcode/extended op ->
// micro-op class, ALU op, stack-pointer delta and operand index selects.
module sik_op_classify
  import sik_pkg::*;
(
  input  logic [3:0] i_opcode,
  input  logic [3:0] i_xop,
  output uop_ctl_t   o_ctl
);

  // Decode table; anything not listed falls out as SYS (halts the thread).
  always_comb begin
    o_ctl.cls     = CLS_SYS;
    o_ctl.alu_op  = ALU_PASS;
    o_ctl.delta   = SPD_NONE;
    o_ctl.src_sel = SRC_NONE;
    o_ctl.dst_sel = DST_NONE;
    o_ctl.is_pre  = 1'b0;
    case (i_opcode)
      OPopr: begin
        case (i_xop)
          OPadd, OPsub, OPand, OPor, OPxor, OPlt: begin
            o_ctl.cls     = CLS_ALU;
            o_ctl.alu_op  = i_xop;
            o_ctl.delta   = SPD_DEC;
            o_ctl.src_sel = SRC_SP;
            o_ctl.dst_sel = DST_SP_MINUS1;
          end
          OPpop: begin
            o_ctl.cls     = CLS_POP;
            o_ctl.delta   = SPD_DEC;
            o_ctl.src_sel = SRC_SP;
          end
          OPret: begin
            o_ctl.cls     = CLS_RET;
            o_ctl.delta   = SPD_DEC;
            o_ctl.src_sel = SRC_SP;
          end
          OPdup: begin
            o_ctl.cls     = CLS_DUP;
            o_ctl.delta   = SPD_INC;
            o_ctl.dst_sel = DST_SP_PLUS1;
          end
          OPtest: begin
            o_ctl.cls     = CLS_TEST;
            o_ctl.src_sel = SRC_SP;
            o_ctl.dst_sel = DST_SP;
          end
          default: o_ctl.cls = CLS_SYS;
        endcase
      end
      OPget: begin
        o_ctl.cls     = CLS_GET;
        o_ctl.delta   = SPD_INC;
        o_ctl.src_sel = SRC_SP_MINUS_IMM;
        o_ctl.dst_sel = DST_SP_PLUS1;
      end
      OPput: begin
        o_ctl.cls     = CLS_PUT;
        o_ctl.src_sel = SRC_SP;
        o_ctl.dst_sel = DST_SP_MINUS_IMM;
      end
      OPpush: begin
        o_ctl.cls     = CLS_PUSH;
        o_ctl.delta   = SPD_INC;
        o_ctl.dst_sel = DST_SP_PLUS1;
      end
      OPload: begin
        o_ctl.cls     = CLS_LOAD;
        o_ctl.src_sel = SRC_SP;
        o_ctl.dst_sel = DST_SP;
      end
      OPstore: begin
        o_ctl.cls     = CLS_STORE;
        o_ctl.delta   = SPD_DEC;
        o_ctl.src_sel = SRC_SP;
        o_ctl.dst_sel = DST_SP_MINUS1;
      end
      OPcall: begin
        o_ctl.cls     = CLS_CALL;
        o_ctl.delta   = SPD_INC;
        o_ctl.dst_sel = DST_SP_PLUS1;
      end
      OPjump:  o_ctl.cls = CLS_JUMP;
      OPjumpf: begin
        o_ctl.cls     = CLS_JUMPF;
        o_ctl.delta   = SPD_DEC;
        o_ctl.src_sel = SRC_SP;
      end
      OPjumpt: begin
        o_ctl.cls     = CLS_JUMPT;
        o_ctl.delta   = SPD_DEC;
        o_ctl.src_sel = SRC_SP;
      end
      OPpre:   o_ctl.is_pre = 1'b1;
      default: o_ctl.cls = CLS_SYS;
    endcase
  end

endmodule

// File: rtl/sik_decode_stage.sv
// SIK decode stage: per-thread prefix/SP/halt state, immediate resolution,
// regfile index generation and a one-entry output register.
// Optional macro SIK_STACK_CHECK_EN adds the trap output and converts
// stack overflow/underflow into SYS instead of wrapping silently.
module sik_decode_stage #(
  parameter int              WORD_W  = 16,
  parameter int              SP_W    = 8,
  parameter logic [SP_W-1:0] SP_INIT = sik_pkg::SP_INIT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_tid,
  input  logic [WORD_W-1:0] in_pc,
  input  logic [WORD_W-1:0] in_inst,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_tid,
  output logic [WORD_W-1:0] out_pc,
  output logic [3:0]        out_op,
  output logic [3:0]        out_cls,
  output logic [WORD_W-1:0] out_imm,
  output logic [SP_W:0]     out_src,
  output logic [SP_W:0]     out_dst,
  input  logic              flush,
  input  logic              flush_tid,
  input  logic [SP_W-1:0]   flush_sp,
  output logic [1:0]        halted
`ifdef SIK_STACK_CHECK_EN
  ,
  output logic              trap
`endif
);
  import sik_pkg::*;

  uop_ctl_t        w_ctl;
  logic [SP_W-1:0] w_sp_thr [2];
  logic [3:0]      w_pre_thr [2];
  logic [1:0]      w_loaded;
  logic [1:0]      w_halted;
  logic [SP_W-1:0] w_sp, w_off, w_sp_next;
  logic [WORD_W-1:0] w_imm;
  logic            w_flush_in, w_accept, w_emit, w_trap;
  cls_e            w_cls;
  logic [SP_W:0]   w_src, w_dst;

  logic              r_out_valid, r_out_tid, r_trap;
  logic [WORD_W-1:0] r_out_pc, r_out_imm;
  logic [3:0]        r_out_op, r_out_cls;
  logic [SP_W:0]     r_out_src, r_out_dst;

  sik_op_classify u_classify (
    .i_opcode (in_inst[15:12]),
    .i_xop    (in_inst[3:0]),
    .o_ctl    (w_ctl)
  );

  assign w_sp  = w_sp_thr[in_tid];
  assign w_off = w_imm[SP_W-1:0];
  // A pending prefix supplies the top nibble; otherwise sign-extend immed12.
  assign w_imm = w_loaded[in_tid] ? {w_pre_thr[in_tid], in_inst[11:0]}
                                  : {{(WORD_W-12){in_inst[11]}}, in_inst[11:0]};

  // Words that will be dropped (halted thread, same-thread flush) never need
  // the output register, so they are consumed even while it is stalled.
  assign w_flush_in = flush && (flush_tid == in_tid);
  assign in_ready   = !r_out_valid || out_ready || w_halted[in_tid] || w_flush_in;
  assign w_accept   = in_valid && (!r_out_valid || out_ready) && !w_halted[in_tid] && !w_flush_in;
  assign w_emit     = w_accept && !w_ctl.is_pre;

`ifdef SIK_STACK_CHECK_EN
  // Overflow: pushing from SP_INIT-1 onto SP_INIT; underflow: popping an empty stack.
  assign w_trap = ((w_ctl.delta == SPD_INC) && (w_sp == SP_INIT - SP_W'(1))) ||
                  ((w_ctl.delta == SPD_DEC) && (w_sp == SP_INIT));
  assign trap   = r_trap;
`else
  assign w_trap = 1'b0;
`endif

  // Resolve class, next SP and regfile indices for the incoming word.
  always_comb begin
    w_cls     = w_trap ? CLS_SYS : w_ctl.cls;
    w_sp_next = w_sp;
    if (!w_trap) begin
      case (w_ctl.delta)
        SPD_INC: w_sp_next = w_sp + SP_W'(1);
        SPD_DEC: w_sp_next = w_sp - SP_W'(1);
        default: w_sp_next = w_sp;
      endcase
    end
    w_src = '0;
    case (w_ctl.src_sel)
      SRC_SP:           w_src = {in_tid, w_sp};
      SRC_SP_MINUS_IMM: w_src = {in_tid, w_sp - w_off};
      default:          w_src = '0;
    endcase
    w_dst = '0;
    case (w_ctl.dst_sel)
      DST_SP:           w_dst = {in_tid, w_sp};
      DST_SP_PLUS1:     w_dst = {in_tid, w_sp + SP_W'(1)};
      DST_SP_MINUS1:    w_dst = {in_tid, w_sp - SP_W'(1)};
      DST_SP_MINUS_IMM: w_dst = {in_tid, w_sp - w_off};
      default:          w_dst = '0;
    endcase
    if (w_trap) begin
      w_src = '0;
      w_dst = '0;
    end
  end

  // Output register: load on emit, drop on consume or same-thread flush.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_out_valid <= 1'b0;
      r_out_tid   <= 1'b0;
      r_out_pc    <= '0;
      r_out_op    <= '0;
      r_out_cls   <= '0;
      r_out_imm   <= '0;
      r_out_src   <= '0;
      r_out_dst   <= '0;
      r_trap      <= 1'b0;
    end else if (w_emit) begin
      r_out_valid <= 1'b1;
      r_out_tid   <= in_tid;
      r_out_pc    <= in_pc;
      r_out_op    <= w_trap ? ALU_PASS : w_ctl.alu_op;
      r_out_cls   <= w_cls;
      r_out_imm   <= w_imm;
      r_out_src   <= w_src;
      r_out_dst   <= w_dst;
      r_trap      <= w_trap;
    end else if (out_ready || (flush && (r_out_tid == flush_tid))) begin
      r_out_valid <= 1'b0;
      r_trap      <= 1'b0;
    end
  end

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_thread
      logic [SP_W-1:0] r_sp;
      logic [3:0]      r_pre;
      logic            r_loaded, r_halted;

      // Per-thread architectural state; flush outranks any accepted word.
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          r_sp     <= SP_INIT;
          r_pre    <= '0;
          r_loaded <= 1'b0;
          r_halted <= 1'b0;
        end else if (flush && (flush_tid == 1'(gi))) begin
          r_sp     <= flush_sp;
          r_loaded <= 1'b0;
        end else if (w_accept && (in_tid == 1'(gi))) begin
          if (w_ctl.is_pre) begin
            r_pre    <= in_inst[3:0];
            r_loaded <= 1'b1;
          end else begin
            r_loaded <= 1'b0;
            r_sp     <= w_sp_next;
            if (w_cls == CLS_SYS) r_halted <= 1'b1;
          end
        end
      end

      assign w_sp_thr[gi]  = r_sp;
      assign w_pre_thr[gi] = r_pre;
      assign w_loaded[gi]  = r_loaded;
      assign w_halted[gi]  = r_halted;
    end
  endgenerate

  assign out_valid = r_out_valid;
  assign out_tid   = r_out_tid;
  assign out_pc    = r_out_pc;
  assign out_op    = r_out_op;
  assign out_cls   = r_out_cls;
  assign out_imm   = r_out_imm;
  assign out_src   = r_out_src;
  assign out_dst   = r_out_dst;
  assign halted    = w_halted;

endmodule

// File: tb/tb_sik_decode_stage.sv
// Directed testbench for sik_decode_stage with immediate-assertion checks.
module tb_sik_decode_stage;

  logic        clk = 1'b0;
  logic        reset, in_valid, in_ready, in_tid;
  logic [15:0] in_pc, in_inst;
  logic        out_valid, out_ready, out_tid;
  logic [15:0] out_pc, out_imm;
  logic [3:0]  out_op, out_cls;
  logic [8:0]  out_src, out_dst;
  logic        flush, flush_tid;
  logic [7:0]  flush_sp;
  logic [1:0]  halted;
`ifdef SIK_STACK_CHECK_EN
  logic        trap;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sik_decode_stage dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_tid    (in_tid),
    .in_pc     (in_pc),
    .in_inst   (in_inst),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_tid   (out_tid),
    .out_pc    (out_pc),
    .out_op    (out_op),
    .out_cls   (out_cls),
    .out_imm   (out_imm),
    .out_src   (out_src),
    .out_dst   (out_dst),
    .flush     (flush),
    .flush_tid (flush_tid),
    .flush_sp  (flush_sp),
    .halted    (halted)
`ifdef SIK_STACK_CHECK_EN
    ,
    .trap      (trap)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_uop(input string tag, input logic t, input logic [3:0] cls,
                         input logic [15:0] imm, input logic [8:0] src, input logic [8:0] dst);
    chk({tag, ".valid"}, 32'(out_valid), 32'd1);
    chk({tag, ".tid"},   32'(out_tid),   32'(t));
    chk({tag, ".cls"},   32'(out_cls),   32'(cls));
    chk({tag, ".imm"},   32'(out_imm),   32'(imm));
    chk({tag, ".src"},   32'(out_src),   32'(src));
    chk({tag, ".dst"},   32'(out_dst),   32'(dst));
  endtask

  // One word presented for one clock edge; outputs are sampled 1 time unit later.
  task automatic drive(input logic t, input logic [15:0] pc, input logic [15:0] inst);
    in_valid = 1'b1;
    in_tid   = t;
    in_pc    = pc;
    in_inst  = inst;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    $display("txn tid=%0d pc=%h inst=%h -> out_valid=%0d cls=%h imm=%h src=%h dst=%h halted=%b",
             t, pc, inst, out_valid, out_cls, out_imm, out_src, out_dst, halted);
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0; in_valid = 1'b0; in_tid = 1'b0; in_pc = '0; in_inst = '0;
    out_ready = 1'b1; flush = 1'b0; flush_tid = 1'b0; flush_sp = '0;
    #1;
    chk("rst.out_valid", 32'(out_valid), 32'd0);
    chk("rst.in_ready",  32'(in_ready),  32'd1);
    chk("rst.halted",    32'(halted),    32'd0);
    chk("rst.imm",       32'(out_imm),   32'd0);
    chk("rst.dst",       32'(out_dst),   32'd0);
    #11;
    reset = 1'b1;

    // Basic PUSH per thread, sign extension of immed12.
    drive(1'b0, 16'h0010, 16'h3005);
    chk_uop("push0", 1'b0, 4'h1, 16'h0005, 9'h000, 9'h000);
    chk("push0.pc", 32'(out_pc), 32'h0010);
    chk("push0.op", 32'(out_op), 32'hF);
`ifdef SIK_STACK_CHECK_EN
    chk("push0.trap", 32'(trap), 32'd0);
`endif
    drive(1'b1, 16'h0020, 16'h3FFF);
    chk_uop("push1", 1'b1, 4'h1, 16'hFFFF, 9'h000, 9'h100);

    // Prefix: PRE emits nothing, next op consumes it, the following does not.
    drive(1'b0, 16'h0011, 16'hF00A);
    chk("pre.out_valid", 32'(out_valid), 32'd0);
    drive(1'b0, 16'h0012, 16'h3123);
    chk_uop("prepush", 1'b0, 4'h1, 16'hA123, 9'h000, 9'h001);
    drive(1'b0, 16'h0013, 16'h3001);
    chk_uop("postpre", 1'b0, 4'h1, 16'h0001, 9'h000, 9'h002);

    // SP0 -> 3, then ADD and GET 2.
    drive(1'b0, 16'h0014, 16'h3000);
    chk_uop("push3", 1'b0, 4'h1, 16'h0000, 9'h000, 9'h003);
    drive(1'b0, 16'h0015, 16'h0000);
    chk_uop("add", 1'b0, 4'h0, 16'h0000, 9'h003, 9'h002);
    chk("add.op", 32'(out_op), 32'h0);
    drive(1'b0, 16'h0016, 16'h1002);
    chk_uop("get2", 1'b0, 4'h2, 16'h0002, 9'h000, 9'h003);
    idle();
    chk("drain.out_valid", 32'(out_valid), 32'd0);

    // Backpressure: output holds, nothing lost on release.
    out_ready = 1'b0;
    drive(1'b0, 16'h0040, 16'h3007);
    chk_uop("stall.first", 1'b0, 4'h1, 16'h0007, 9'h000, 9'h004);
    in_valid = 1'b1; in_tid = 1'b0; in_pc = 16'h0041; in_inst = 16'h3008;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("stall.in_ready", 32'(in_ready), 32'd0);
      chk("stall.pc",       32'(out_pc),   32'h0040);
      chk("stall.imm",      32'(out_imm),  32'h0007);
    end
    out_ready = 1'b1;
    #1;
    chk("release.in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk_uop("release", 1'b0, 4'h1, 16'h0008, 9'h000, 9'h005);
    chk("release.pc", 32'(out_pc), 32'h0041);
    idle();
    chk("release.drain", 32'(out_valid), 32'd0);

    // Flush of tid1 kills its pending micro-op and restores SP1.
    out_ready = 1'b0;
    drive(1'b1, 16'h0050, 16'h3055);
    chk_uop("f1.pending", 1'b1, 4'h1, 16'h0055, 9'h000, 9'h101);
    flush = 1'b1; flush_tid = 1'b1; flush_sp = 8'h10;
    idle();
    flush = 1'b0;
    out_ready = 1'b1;
    chk("f1.out_valid", 32'(out_valid), 32'd0);
    drive(1'b1, 16'h0051, 16'h3001);
    chk_uop("f1.push", 1'b1, 4'h1, 16'h0001, 9'h000, 9'h111);

    // Flush of the other thread leaves an accepted tid0 word alone.
    flush = 1'b1; flush_tid = 1'b1; flush_sp = 8'h20;
    drive(1'b0, 16'h0042, 16'h3009);
    flush = 1'b0;
    chk_uop("fother", 1'b0, 4'h1, 16'h0009, 9'h000, 9'h006);
    drive(1'b1, 16'h0052, 16'h3001);
    chk_uop("fother.t1", 1'b1, 4'h1, 16'h0001, 9'h000, 9'h121);

    // Same-thread flush drops the incoming word.
    flush = 1'b1; flush_tid = 1'b0; flush_sp = 8'h30;
    #1;
    chk("fsame.in_ready", 32'(in_ready), 32'd1);
    drive(1'b0, 16'h0043, 16'h300A);
    flush = 1'b0;
    chk("fsame.out_valid", 32'(out_valid), 32'd0);
    drive(1'b0, 16'h0044, 16'h300B);
    chk_uop("fsame.push", 1'b0, 4'h1, 16'h000B, 9'h000, 9'h031);
    drive(1'b0, 16'h0045, 16'h2001);
    chk_uop("put1", 1'b0, 4'h3, 16'h0001, 9'h031, 9'h030);

    // Wrap-around on tid1: 0x00-1 -> 0xFF, 0xFF+1 -> 0x00.
    flush = 1'b1; flush_tid = 1'b1; flush_sp = 8'h00;
    idle();
    flush = 1'b0;
    drive(1'b1, 16'h0060, 16'h0006);
    chk_uop("pop0", 1'b1, 4'h4, 16'h0006, 9'h100, 9'h000);
    drive(1'b1, 16'h0061, 16'h3001);
    chk_uop("pushwrap", 1'b1, 4'h1, 16'h0001, 9'h000, 9'h100);

    // SYS halts tid0; its later words vanish while tid1 runs on.
    drive(1'b0, 16'h0046, 16'hA000);
    chk_uop("sys", 1'b0, 4'hE, 16'h0000, 9'h000, 9'h000);
    chk("sys.halted", 32'(halted), 32'b01);
    in_tid = 1'b0;
    #1;
    chk("halted.in_ready", 32'(in_ready), 32'd1);
    drive(1'b0, 16'h0047, 16'h3001);
    chk("halted.drop", 32'(out_valid), 32'd0);
    drive(1'b1, 16'h0062, 16'h3002);
    chk_uop("t1.after", 1'b1, 4'h1, 16'h0002, 9'h000, 9'h101);
    chk("t1.halted", 32'(halted), 32'b01);

    // POP at an empty stack (SP=0xFF).
    flush = 1'b1; flush_tid = 1'b1; flush_sp = 8'hFF;
    idle();
    flush = 1'b0;
    drive(1'b1, 16'h0063, 16'h0006);
`ifdef SIK_STACK_CHECK_EN
    chk_uop("underflow", 1'b1, 4'hE, 16'h0006, 9'h000, 9'h000);
    chk("underflow.trap",   32'(trap),   32'd1);
    chk("underflow.halted", 32'(halted), 32'b11);
    idle();
    chk("trap.pulse", 32'(trap), 32'd0);
`else
    chk_uop("popff", 1'b1, 4'h4, 16'h0006, 9'h1FF, 9'h000);
    drive(1'b1, 16'h0064, 16'h3003);
    chk_uop("pushfe", 1'b1, 4'h1, 16'h0003, 9'h000, 9'h1FF);
    chk("final.halted", 32'(halted), 32'b01);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
